problem5_reg_mux: RTL and testbench

//   Registered 4-to-1 data selector. Each clock, one of four data words, chosen by
//   a 2-bit control, is captured into the output register.

---
 rtl/problem5_reg_mux.sv | 61 ++++++
 tb/tb_problem5_reg_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/problem5_reg_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// problem5_reg_mux
//   Registered 4-to-1 data selector used as the operand/result select stage.
//   Every rising clock edge captures one of four candidate words, chosen by a
//   2-bit code, into the output register. The register adds one cycle of latency.
//
// Ports
//   i_clk      in   1      clock, rising-edge active
//   i_rst_n    in   1      asynchronous, active-low reset; forces RESET_VALUE
//   i_data_0   in   WIDTH  candidate word for i_ctrl == 0
//   i_data_1   in   WIDTH  candidate word for i_ctrl == 1
//   i_data_2   in   WIDTH  candidate word for i_ctrl == 2
//   i_data_3   in   WIDTH  candidate word for i_ctrl == 3
//   i_ctrl     in   2      select code, fully decoded
//   o_data     out  WIDTH  registered selected word
// -----------------------------------------------------------------------------
module problem5_reg_mux #(
    parameter int                 WIDTH       = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data_0,
    input  logic [WIDTH-1:0] i_data_1,
    input  logic [WIDTH-1:0] i_data_2,
    input  logic [WIDTH-1:0] i_data_3,
    input  logic [1:0]       i_ctrl,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;

    // Every 2-bit code maps to an input, so the default arm is the code-3
    // input and there is no illegal select.
    always_comb begin
        data_next = i_data_3;
        case (i_ctrl)
            2'd0:    data_next = i_data_0;
            2'd1:    data_next = i_data_1;
            2'd2:    data_next = i_data_2;
            default: data_next = i_data_3;
        endcase
    end

    // Reload on every edge: no enable, no hold. Reset is asynchronous so the
    // output goes to RESET_VALUE without waiting for a clock; any capture
    // that would have happened at the next edge is simply lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg <= RESET_VALUE;
        end else begin
            data_reg <= data_next;
        end
    end

    // Output comes straight from the register, never from the inputs.
    assign o_data = data_reg;

endmodule

// File: tb/tb_problem5_reg_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_problem5_reg_mux
//   Scoreboard bench for problem5_reg_mux. Stimulus is applied on the falling
//   edge and the expected word (chosen from an array indexed by the select
//   code) is queued; a monitor pops and compares 0.2 after each rising edge.
//   Asynchronous reset behaviour and mid-cycle stability are checked directly.
// -----------------------------------------------------------------------------
module tb_problem5_reg_mux;

    localparam int          WIDTH = 16;
    localparam logic [15:0] RST_V = 16'h0000;

    logic             i_clk;
    logic             i_rst_n;
    logic [WIDTH-1:0] i_data_0;
    logic [WIDTH-1:0] i_data_1;
    logic [WIDTH-1:0] i_data_2;
    logic [WIDTH-1:0] i_data_3;
    logic [1:0]       i_ctrl;
    logic [WIDTH-1:0] o_data;

    problem5_reg_mux #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RST_V)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_data_0 (i_data_0),
        .i_data_1 (i_data_1),
        .i_data_2 (i_data_2),
        .i_data_3 (i_data_3),
        .i_ctrl   (i_ctrl),
        .o_data   (o_data)
    );

    // Period 2 time units: rising edges at 1, 3, 5, ...
    initial i_clk = 1'b0;
    always #1 i_clk = ~i_clk;

    logic [WIDTH-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] last_exp = RST_V;

    task automatic check(input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp,
                         input string name);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end else begin
            $display("ok   %s at %0t: o_data %h", name, $time, act);
        end
    endtask

    // Reference: selected word is simply the entry at position ctrl.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, b, c, d,
                                               input logic [1:0] s);
        logic [WIDTH-1:0] words [4];
        words[0] = a; words[1] = b; words[2] = c; words[3] = d;
        return words[s];
    endfunction

    // Drive inputs now and queue the word the next rising edge must capture.
    task automatic apply(input logic [WIDTH-1:0] a, b, c, d, input logic [1:0] s);
        i_data_0 = a; i_data_1 = b; i_data_2 = c; i_data_3 = d; i_ctrl = s;
        exp_q.push_back(model(a, b, c, d, s));
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, b, c, d, input logic [1:0] s);
        @(negedge i_clk);
        apply(a, b, c, d, s);
    endtask

    // Assert reset between edges: output must clear at once and the capture
    // queued for the coming edge is dropped.
    task automatic async_reset(input string name);
        i_rst_n = 1'b0;
        exp_q.delete();
        last_exp = RST_V;
        #0.1;
        check(o_data, RST_V, name);
    endtask

    // Monitor: compare after every rising edge.
    always begin
        @(posedge i_clk);
        #0.2;
        if (!i_rst_n) begin
            check(o_data, RST_V, "reset_hold");
        end else if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check(o_data, last_exp, "capture");
        end
    end

    initial begin
        i_rst_n  = 1'b1;
        i_data_0 = 16'h1234; i_data_1 = 16'h5678;
        i_data_2 = 16'h9abc; i_data_3 = 16'hdef0;
        i_ctrl   = 2'd1;

        // 1. Reset before any rising edge, with data present.
        #0.3;
        async_reset("reset_no_clock");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #0.1;
        check(o_data, RST_V, "release_no_edge");
        #0.1;
        apply(16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 2'd1);

        // 2/3. Basic selection, one edge after each ctrl change.
        for (int s = 0; s < 4; s++)
            drive(16'h000a, 16'h000b, 16'h000c, 16'h000d, 2'(s));

        // 4. ctrl 0 -> 3 between edges.
        drive(16'h000a, 16'h000b, 16'h000c, 16'h000d, 2'd0);
        @(posedge i_clk);
        #0.6;
        i_ctrl = 2'd3;
        exp_q.push_back(16'h000d);
        #0.2;
        check(o_data, 16'h000a, "midcycle_hold");
        @(negedge i_clk);
        check(o_data, 16'h000a, "midcycle_hold2");

        // 5. Bit-exact pass-through of wide patterns.
        for (int s = 0; s < 4; s++)
            drive(16'hffff, 16'h8001, 16'h5555, 16'haaaa, 2'(s));

        // 6. Reset halfway between edges while o_data = 000d, with a capture pending.
        drive(16'h000a, 16'h000b, 16'h000c, 16'h000d, 2'd3);
        @(posedge i_clk);
        @(negedge i_clk);
        apply(16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'd0);
        #0.5;
        async_reset("reset_midcycle");
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        apply(16'h0001, 16'h0002, 16'h0003, 16'h0004, 2'd2);

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 200; n++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)));
            if ($urandom_range(0, 19) == 0) begin
                #0.5;
                async_reset("reset_random");
                @(posedge i_clk);
                @(negedge i_clk);
                i_rst_n = 1'b1;
                apply(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      2'($urandom_range(0, 3)));
            end else if ($urandom_range(0, 4) == 0) begin
                // Random mid-cycle wiggle of data after the queued sample:
                // must not leak before the edge.
                #0.4;
                i_data_0 = ~i_data_0;
                #0.2;
                check(o_data, last_exp, "random_stable");
                @(posedge i_clk);
                #0.1;
                // Edge captures the wiggled word, so requeue the true target.
                exp_q.delete();
                exp_q.push_back(model(i_data_0, i_data_1, i_data_2, i_data_3, i_ctrl));
            end
        end

        repeat (3) @(posedge i_clk);
        #0.5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected words never compared, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
